// File: rtl/ext_clkgen.sv
// rtl/ext_clkgen.sv - derives GS/SAA/YM clocks and the GS periodic interrupt from clk32
module ext_clkgen #(
  parameter int YM_INC  = 7,
  parameter int YM_BITS = 7,
  parameter int INT_INC = 3,
  parameter int INT_MOD = 2560,
  parameter int INT_MAX = 256
) (
  input  logic       clk32,
  input  logic       rst_n,
  input  logic [1:0] gclk_sel,
  input  logic       n_gm1,
  input  logic       n_giorq,
  output logic       gclk,
  output logic       saa_clk,
  output logic       ym_m,
  output logic       n_gint
);

  localparam int TW = (INT_MAX > 1) ? $clog2(INT_MAX) : 1;
  localparam logic [11:0]   INC12 = 12'(INT_INC);
  localparam logic [11:0]   MOD12 = 12'(INT_MOD);
  localparam logic [TW-1:0] TLAST = TW'(INT_MAX - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [1:0]         saa_cnt;
  logic [YM_BITS-1:0] ym_acc;
  logic [1:0]         gsel, gsel_n;
  logic [1:0]         gcnt, gcnt_n;
  logic               gclk_n;
  logic [11:0]        iacc, iacc_sum;
  logic               tick;
  logic [1:0]         m1_sync, iorq_sync;
  logic               ack, ack_prev, ack_edge;
  state_t             state, state_n;
  logic [TW-1:0]      tcnt, tcnt_n;

  // SAA clock is the MSB of a free-running divide-by-4 counter
  assign saa_clk = saa_cnt[1];

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      saa_cnt <= '0;
      ym_acc  <= '0;
      ym_m    <= 1'b0;
    end else begin
      saa_cnt <= saa_cnt + 2'd1;
      ym_acc  <= ym_acc + YM_BITS'(YM_INC);
      ym_m    <= ym_acc[YM_BITS-1];
    end
  end

  function automatic logic [1:0] div_last(input logic [1:0] s);
    case (s)
      2'b00:   div_last = 2'd1;
      2'b01:   div_last = 2'd2;
      2'b10:   div_last = 2'd3;
      default: div_last = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] div_high(input logic [1:0] s);
    case (s)
      2'b00:   div_high = 2'd1;
      2'b01:   div_high = 2'd2;
      2'b10:   div_high = 2'd2;
      default: div_high = 2'd0;
    endcase
  endfunction

  // New selection only takes effect on a period boundary, so no runt pulses
  always_comb begin
    gsel_n = gsel;
    gcnt_n = gcnt + 2'd1;
    if (gsel == 2'b11 || gcnt == div_last(gsel)) begin
      gsel_n = gclk_sel;
      gcnt_n = 2'd0;
    end
    gclk_n = (gsel_n != 2'b11) && (gcnt_n < div_high(gsel_n));
  end

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      gsel <= 2'b00;
      gcnt <= 2'd0;
      gclk <= 1'b0;
    end else begin
      gsel <= gsel_n;
      gcnt <= gcnt_n;
      gclk <= gclk_n;
    end
  end

  assign iacc_sum = iacc + INC12;
  assign tick     = (iacc_sum >= MOD12);

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      iacc <= '0;
    end else begin
      iacc <= tick ? (iacc_sum - MOD12) : iacc_sum;
    end
  end

  // Acknowledge needs a fresh assertion: a held-low M1+IORQ clears only once
  assign ack      = ~m1_sync[1] & ~iorq_sync[1];
  assign ack_edge = ack & ~ack_prev;

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      m1_sync   <= 2'b00;
      iorq_sync <= 2'b00;
      ack_prev  <= 1'b0;
    end else begin
      m1_sync   <= {m1_sync[0], n_gm1};
      iorq_sync <= {iorq_sync[0], n_giorq};
      ack_prev  <= ack;
    end
  end

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    case (state)
      IDLE: begin
        if (tick) begin
          state_n = ACTIVE;
          tcnt_n  = '0;
        end
      end
      ACTIVE: begin
        if (ack_edge) begin
          state_n = IDLE;
        end else if (tick) begin
          tcnt_n = '0;
        end else if (tcnt == TLAST) begin
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
    end
  end

  assign n_gint = (state == IDLE);

endmodule
